// File: rtl/pipe_stage_skid_if.sv
// Valid/ready/data handshake bundle used on both sides of a pipeline stage.
//
// Modports:
//   master - drives valid and data, observes ready (the producing side)
//   slave  - observes valid and data, drives ready (the consuming side)
//
// Signals:
//   valid  producer has a live payload on data
//   ready  consumer can take the payload this cycle
//   data   payload, DATA_W bits

interface pipe_stage_skid_if #(
  parameter int unsigned DATA_W = 32
) ();

  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;

  modport master (
    output valid,
    output data,
    input  ready
  );

  modport slave (
    input  valid,
    input  data,
    output ready
  );

endinterface

// File: rtl/pipe_stage_skid.sv
// Elastic pipeline stage with a one-entry skid buffer.
//
// A head register (main) drives the downstream payload. A second register (skid) catches the
// one payload that can still arrive after downstream stalls. Because of the skid register,
// in_ready can be registered: it only depends on the stage's own next state, never on
// out_ready in the same cycle. This cuts the ready path between stages.
//
// Whenever out_valid is low, out_data shows NOP_DATA. This lets a bubble look like a harmless
// instruction downstream. A saturating counter records cycles where a payload was held but
// downstream refused it.
//
// Parameters:
//   DATA_W    payload width
//   NOP_DATA  value shown on out_data while out_valid is low
//   CNT_W     stall counter width
//
// Ports:
//   clk        clock; all state changes on the rising edge
//   rst        synchronous active-high reset; overrides flush
//   flush      drop the held entries and any incoming payload this cycle
//   in_if      upstream side (slave):  valid/data in, registered ready out
//   out_if     downstream side (master): valid/data out, ready in
//   stall_cnt  cycles with out_valid=1 and out_ready=0, saturating, cleared only by rst

module pipe_stage_skid #(
  parameter int unsigned       DATA_W   = 32,
  parameter logic [DATA_W-1:0] NOP_DATA = DATA_W'(32'h0000_4000),
  parameter int unsigned       CNT_W    = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  pipe_stage_skid_if.slave        in_if,
  pipe_stage_skid_if.master       out_if,
  output logic [CNT_W-1:0]        stall_cnt
);

  typedef enum logic [1:0] {
    StEmpty,
    StOne,
    StFull
  } state_e;

  state_e            state_q;
  logic [DATA_W-1:0] main_q;
  logic [DATA_W-1:0] skid_q;
  logic              in_ready_q;
  logic              out_valid_q;
  logic [CNT_W-1:0]  stall_cnt_q;

  logic accept;
  logic drain;

  assign accept = in_if.valid & in_ready_q;
  assign drain  = out_valid_q & out_if.ready;

  // The FSM and its registered flags are updated together. in_ready_q and out_valid_q are
  // always the decoded form of the state being entered. This keeps both outputs free of
  // combinational logic.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      // A flush drops the held entries and any incoming payload. A drain in the same cycle
      // is still taken by downstream, so nothing extra is needed for it here.
      state_q     <= StEmpty;
      main_q      <= NOP_DATA;
      skid_q      <= NOP_DATA;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        StEmpty: begin
          if (accept) begin
            main_q      <= in_if.data;
            state_q     <= StOne;
            out_valid_q <= 1'b1;
          end
        end
        StOne: begin
          if (accept && drain) begin
            // The head leaves and the new payload takes its place in the same cycle.
            main_q <= in_if.data;
          end else if (accept) begin
            // Downstream stalled. Park the late arrival in the skid register, then close
            // the input.
            skid_q     <= in_if.data;
            state_q    <= StFull;
            in_ready_q <= 1'b0;
          end else if (drain) begin
            state_q     <= StEmpty;
            out_valid_q <= 1'b0;
          end
        end
        StFull: begin
          // in_ready is low here, so only a drain can happen.
          if (drain) begin
            main_q     <= skid_q;
            state_q    <= StOne;
            in_ready_q <= 1'b1;
          end
        end
        default: begin
          state_q     <= StEmpty;
          main_q      <= NOP_DATA;
          skid_q      <= NOP_DATA;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  // Counts only real stalls: a held payload that downstream refused. Flush does not clear it.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else if (out_valid_q && !out_if.ready && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_q <= stall_cnt_q + CNT_W'(1);
    end
  end

  assign in_if.ready  = in_ready_q;
  assign out_if.valid = out_valid_q;
  // Stale main contents are hidden behind NOP_DATA whenever nothing live is held.
  assign out_if.data  = out_valid_q ? main_q : NOP_DATA;
  assign stall_cnt    = stall_cnt_q;

  // The registered flags must always agree with the state encoding.
  ready_matches_state: assert property (@(posedge clk) disable iff (rst)
    in_ready_q == (state_q != StFull));
  valid_matches_state: assert property (@(posedge clk) disable iff (rst)
    out_valid_q == (state_q != StEmpty));

endmodule

// File: tb/tb_pipe_stage_skid.sv
module tb_pipe_stage_skid;

  localparam logic [31:0] NOP = 32'h0000_4000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic [15:0] stall_cnt;

  logic        rst_s = 1'b1;
  logic        flush_s = 1'b0;
  logic [3:0]  sat_cnt;

  pipe_stage_skid_if #(.DATA_W(32)) in_if ();
  pipe_stage_skid_if #(.DATA_W(32)) out_if ();
  pipe_stage_skid_if #(.DATA_W(32)) sat_in_if ();
  pipe_stage_skid_if #(.DATA_W(32)) sat_out_if ();

  pipe_stage_skid #(.DATA_W(32), .NOP_DATA(NOP), .CNT_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_if     (in_if),
    .out_if    (out_if),
    .stall_cnt (stall_cnt)
  );

  pipe_stage_skid #(.DATA_W(32), .NOP_DATA(NOP), .CNT_W(4)) dut_sat (
    .clk       (clk),
    .rst       (rst_s),
    .flush     (flush_s),
    .in_if     (sat_in_if),
    .out_if    (sat_out_if),
    .stall_cnt (sat_cnt)
  );

  always #5 clk = ~clk;

  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] sb[$];
  logic [15:0] exp_stall = '0;
  logic        acc;

  // Apply one cycle of stimulus. Before the edge, check the outputs against the scoreboard.
  // After that, advance the model the same way the edge advances the DUT.
  task automatic step(input logic v, input logic [31:0] d, input logic ordy, input logic fl,
                      output logic accepted);
    logic        exp_rdy;
    logic        exp_vld;
    logic [31:0] exp_data;
    in_if.valid  = v;
    in_if.data   = d;
    out_if.ready = ordy;
    flush        = fl;
    exp_rdy  = (sb.size() < 2);
    exp_vld  = (sb.size() != 0);
    exp_data = exp_vld ? sb[0] : NOP;
    vectors++;
    if (in_if.ready !== exp_rdy) begin
      miscompares++;
      $display("FAIL in_ready: got %b expected %b", in_if.ready, exp_rdy);
    end
    vectors++;
    if (out_if.valid !== exp_vld) begin
      miscompares++;
      $display("FAIL out_valid: got %b expected %b", out_if.valid, exp_vld);
    end
    vectors++;
    if (out_if.data !== exp_data) begin
      miscompares++;
      $display("FAIL out_data: got %h expected %h", out_if.data, exp_data);
    end
    vectors++;
    if (stall_cnt !== exp_stall) begin
      miscompares++;
      $display("FAIL stall_cnt: got %0d expected %0d", stall_cnt, exp_stall);
    end
    accepted = v && exp_rdy && !fl;
    if (exp_vld && ordy) void'(sb.pop_front());
    if (accepted) sb.push_back(d);
    if (fl) sb.delete();
    if (exp_vld && !ordy && exp_stall != 16'hFFFF) exp_stall++;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic ordy, input int n);
    logic a;
    for (int i = 0; i < n; i++) step(1'b0, 32'hDEAD_BEEF, ordy, 1'b0, a);
  endtask

  task automatic do_reset();
    rst          = 1'b1;
    in_if.valid  = 1'b0;
    in_if.data   = '0;
    out_if.ready = 1'b0;
    flush        = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    sb.delete();
    exp_stall = '0;
  endtask

  task automatic check_idle_outputs(input string tag);
    vectors++;
    if (in_if.ready !== 1'b1 || out_if.valid !== 1'b0 || out_if.data !== NOP) begin
      miscompares++;
      $display("FAIL %s: got rdy=%b vld=%b data=%h expected rdy=1 vld=0 data=%h",
               tag, in_if.ready, out_if.valid, out_if.data, NOP);
    end
  endtask

  task automatic test_reset();
    do_reset();
    check_idle_outputs("reset_outputs");
    vectors++;
    if (stall_cnt !== 16'd0) begin
      miscompares++;
      $display("FAIL reset_stall_cnt: got %0d expected 0", stall_cnt);
    end
    // Fill the stage, then reset mid-transfer: every held entry must disappear.
    step(1'b1, 32'h1111_0001, 1'b0, 1'b0, acc);
    step(1'b1, 32'h1111_0002, 1'b0, 1'b0, acc);
    do_reset();
    check_idle_outputs("reset_mid_transfer");
    idle(1'b1, 2);
  endtask

  task automatic test_streaming();
    do_reset();
    step(1'b1, 32'hA000_000A, 1'b1, 1'b0, acc);
    vectors++;
    if (out_if.data !== 32'hA000_000A) begin
      miscompares++;
      $display("FAIL stream_latency: got %h expected a000000a", out_if.data);
    end
    step(1'b1, 32'hB000_000B, 1'b1, 1'b0, acc);
    step(1'b1, 32'hC000_000C, 1'b1, 1'b0, acc);
    idle(1'b1, 3);
  endtask

  task automatic test_backpressure();
    int n;
    do_reset();
    step(1'b1, 32'hA1, 1'b0, 1'b0, acc);
    step(1'b1, 32'hB2, 1'b0, 1'b0, acc);
    vectors++;
    if (in_if.ready !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_full_ready: got %b expected 0", in_if.ready);
    end
    for (int i = 0; i < 3; i++) step(1'b1, 32'hC3, 1'b0, 1'b0, acc);
    // The stall is seen in the cycle B is offered and in the three C cycles: 4 stalls.
    vectors++;
    if (stall_cnt !== 16'd4) begin
      miscompares++;
      $display("FAIL bp_stall_cnt: got %0d expected 4", stall_cnt);
    end
    n = 0;
    acc = 1'b0;
    while (!acc && n < 10) begin
      step(1'b1, 32'hC3, 1'b1, 1'b0, acc);
      n++;
    end
    vectors++;
    if (!acc) begin
      miscompares++;
      $display("FAIL bp_c_accept: got no accept expected accept within 10 cycles");
    end
    idle(1'b1, 4);
  endtask

  task automatic test_flush();
    do_reset();
    step(1'b1, 32'hA1, 1'b0, 1'b0, acc);
    step(1'b1, 32'hB2, 1'b0, 1'b0, acc);
    step(1'b1, 32'hD4, 1'b0, 1'b1, acc);
    check_idle_outputs("flush_outputs");
    idle(1'b1, 3);
    // The stall counter survives a flush.
    vectors++;
    if (stall_cnt !== 16'd2) begin
      miscompares++;
      $display("FAIL flush_keeps_stall: got %0d expected 2", stall_cnt);
    end
  endtask

  task automatic test_accept_drain();
    do_reset();
    step(1'b1, 32'hA1, 1'b0, 1'b0, acc);
    step(1'b1, 32'hE5, 1'b1, 1'b0, acc);
    vectors++;
    if (out_if.data !== 32'hE5 || out_if.valid !== 1'b1 || in_if.ready !== 1'b1) begin
      miscompares++;
      $display("FAIL accept_drain: got data=%h vld=%b rdy=%b expected data=e5 vld=1 rdy=1",
               out_if.data, out_if.valid, in_if.ready);
    end
    idle(1'b1, 2);
  endtask

  task automatic test_back_to_back();
    logic        v;
    logic        r;
    logic        f;
    logic [31:0] d;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      v = 1'($urandom_range(0, 1));
      r = ($urandom_range(0, 3) != 0);
      f = ($urandom_range(0, 31) == 0);
      d = $urandom;
      step(v, d, r, f, acc);
    end
    idle(1'b1, 3);
  endtask

  task automatic test_saturation();
    int exp;
    sat_in_if.valid  = 1'b0;
    sat_in_if.data   = '0;
    sat_out_if.ready = 1'b0;
    rst_s = 1'b1;
    @(posedge clk);
    #1;
    rst_s = 1'b0;
    sat_in_if.valid = 1'b1;
    sat_in_if.data  = 32'h1234_5678;
    @(posedge clk);
    #1;
    sat_in_if.valid = 1'b0;
    vectors++;
    if (sat_out_if.valid !== 1'b1 || sat_cnt !== 4'd0) begin
      miscompares++;
      $display("FAIL sat_start: got vld=%b cnt=%0d expected vld=1 cnt=0",
               sat_out_if.valid, sat_cnt);
    end
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      exp = (i > 15) ? 15 : i;
      vectors++;
      if (sat_cnt !== 4'(exp)) begin
        miscompares++;
        $display("FAIL sat_count: got %0d expected %0d", sat_cnt, exp);
      end
    end
    rst_s = 1'b1;
    @(posedge clk);
    #1;
    vectors++;
    if (sat_cnt !== 4'd0 || sat_out_if.valid !== 1'b0) begin
      miscompares++;
      $display("FAIL sat_reset: got cnt=%0d vld=%b expected cnt=0 vld=0",
               sat_cnt, sat_out_if.valid);
    end
    rst_s = 1'b0;
  endtask

  initial begin
    in_if.valid      = 1'b0;
    in_if.data       = '0;
    out_if.ready     = 1'b0;
    sat_in_if.valid  = 1'b0;
    sat_in_if.data   = '0;
    sat_out_if.ready = 1'b0;
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush();
    test_accept_drain();
    test_back_to_back();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
